// File: rtl/bcd_countdown_timer_2d.sv
// Two-digit BCD countdown timer: decade borrow chain, tick prescaler and
// load/start/stop control with a one-cycle expiry pulse.
module bcd_countdown_timer_2d #(
    parameter int PRESCALE = 4
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_units,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        if (d > 4'd9) begin
            return 4'd9;
        end else begin
            return d;
        end
    endfunction

    state_t     state_r;
    logic [7:0] presc_r;
    logic [3:0] tens_r;
    logic [3:0] units_r;
    logic       running_r;
    logic       done_r;

    logic       tick_s;
    logic       nonzero_s;
    logic       hits_zero_s;
    logic [3:0] next_tens_s;
    logic [3:0] next_units_s;

    // Borrow chain: the units wrap 0->9 decrements the tens digit.
    always_comb begin
        tick_s       = (presc_r == PRESC_LAST);
        nonzero_s    = (tens_r != 4'd0) || (units_r != 4'd0);
        next_tens_s  = tens_r;
        next_units_s = units_r;
        if (units_r != 4'd0) begin
            next_units_s = units_r - 4'd1;
        end else begin
            next_units_s = 4'd9;
            if (tens_r != 4'd0) begin
                next_tens_s = tens_r - 4'd1;
            end else begin
                next_tens_s = 4'd0;
            end
        end
        hits_zero_s = (next_tens_s == 4'd0) && (next_units_s == 4'd0);
    end

    // Control FSM, prescaler, digit registers and registered status outputs.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_r   <= ST_IDLE;
            presc_r   <= 8'd0;
            tens_r    <= 4'd9;
            units_r   <= 4'd9;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (load) begin
                // Load outranks every other command, including a tick.
                tens_r    <= clamp_digit(load_tens);
                units_r   <= clamp_digit(load_units);
                presc_r   <= 8'd0;
                state_r   <= ST_IDLE;
                running_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start && !stop && nonzero_s) begin
                            state_r   <= ST_RUN;
                            presc_r   <= 8'd0;
                            running_r <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (stop) begin
                            state_r   <= ST_PAUSED;
                            running_r <= 1'b0;
                        end else if (tick_s) begin
                            presc_r <= 8'd0;
                            tens_r  <= next_tens_s;
                            units_r <= next_units_s;
                            if (hits_zero_s) begin
                                state_r   <= ST_EXPIRED;
                                running_r <= 1'b0;
                                done_r    <= 1'b1;
                            end
                        end else begin
                            presc_r <= presc_r + 8'd1;
                        end
                    end
                    ST_PAUSED: begin
                        // Resume keeps the held prescaler phase.
                        if (start && !stop) begin
                            state_r   <= ST_RUN;
                            running_r <= 1'b1;
                        end
                    end
                    ST_EXPIRED: begin
                        state_r <= ST_EXPIRED;
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        presc_r   <= 8'd0;
                        running_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tens    = tens_r;
    assign units   = units_r;
    assign running = running_r;
    assign done    = done_r;

endmodule

// File: tb/tb_bcd_countdown_timer_2d.sv
// Bench for bcd_countdown_timer_2d: two instances (PRESCALE 4 and 1) checked
// against an integer-valued reference model, a vector table and directed cases.
module tb_bcd_countdown_timer_2d;

    logic       clk = 1'b0;
    logic       clear;
    logic       load;
    logic [3:0] load_tens;
    logic [3:0] load_units;
    logic       start;
    logic       stop;

    logic [3:0] t4, u4, t1, u1;
    logic       r4, d4, r1, d1;

    bcd_countdown_timer_2d #(.PRESCALE(4)) dut4 (
        .clk(clk), .clear(clear), .load(load), .load_tens(load_tens),
        .load_units(load_units), .start(start), .stop(stop),
        .tens(t4), .units(u4), .running(r4), .done(d4)
    );

    bcd_countdown_timer_2d #(.PRESCALE(1)) dut1 (
        .clk(clk), .clear(clear), .load(load), .load_tens(load_tens),
        .load_units(load_units), .start(start), .stop(stop),
        .tens(t1), .units(u1), .running(r1), .done(d1)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: value kept as a plain integer 0..99, with a count of
    // cycles left until the next step.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
    int mv[2];
    int mmode[2];
    int mleft[2];
    int mdone[2];

    function automatic int presc_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mv[k] = 99; mmode[k] = M_IDLE; mleft[k] = presc_of(k); mdone[k] = 0;
        end
    endtask

    task automatic model_edge(input int k);
        int lt, lu;
        mdone[k] = 0;
        if (load) begin
            lt = (load_tens > 9) ? 9 : int'(load_tens);
            lu = (load_units > 9) ? 9 : int'(load_units);
            mv[k] = 10 * lt + lu;
            mmode[k] = M_IDLE;
            mleft[k] = presc_of(k);
        end else if (mmode[k] == M_IDLE) begin
            if (!stop && start && mv[k] != 0) begin
                mmode[k] = M_RUN;
                mleft[k] = presc_of(k);
            end
        end else if (mmode[k] == M_RUN) begin
            if (stop) begin
                mmode[k] = M_PAUSE;
            end else begin
                mleft[k]--;
                if (mleft[k] == 0) begin
                    mv[k]--;
                    mleft[k] = presc_of(k);
                    if (mv[k] == 0) begin
                        mmode[k] = M_EXP;
                        mdone[k] = 1;
                    end
                end
            end
        end else if (mmode[k] == M_PAUSE) begin
            if (!stop && start) mmode[k] = M_RUN;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_models(input string tag);
        check($sformatf("%s.p4.tens", tag), int'(t4), mv[0] / 10);
        check($sformatf("%s.p4.units", tag), int'(u4), mv[0] % 10);
        check($sformatf("%s.p4.running", tag), int'(r4), (mmode[0] == M_RUN) ? 1 : 0);
        check($sformatf("%s.p4.done", tag), int'(d4), mdone[0]);
        check($sformatf("%s.p1.tens", tag), int'(t1), mv[1] / 10);
        check($sformatf("%s.p1.units", tag), int'(u1), mv[1] % 10);
        check($sformatf("%s.p1.running", tag), int'(r1), (mmode[1] == M_RUN) ? 1 : 0);
        check($sformatf("%s.p1.done", tag), int'(d1), mdone[1]);
    endtask

    // One clock: drive inputs, advance the model at the edge, sample #1 later.
    task automatic step(input logic ld, input logic [3:0] lt, input logic [3:0] lu,
                        input logic st, input logic sp, input string tag);
        load = ld; load_tens = lt; load_units = lu; start = st; stop = sp;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_models(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, tag);
    endtask

    task automatic async_clear(input string tag);
        #3 clear = 1'b1;
        #1;
        model_reset();
        check($sformatf("%s.hard.tens", tag), int'(t4), 9);
        check($sformatf("%s.hard.units", tag), int'(u4), 9);
        check($sformatf("%s.hard.running", tag), int'(r4), 0);
        check($sformatf("%s.hard.done", tag), int'(d4), 0);
        check_models(tag);
        #2 clear = 1'b0;
    endtask

    typedef struct {
        logic       ld;
        logic [3:0] lt;
        logic [3:0] lu;
        logic       st;
        logic       sp;
        int         ev;
        int         er;
        int         ed;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic ld, input logic [3:0] lt, input logic [3:0] lu,
                                input logic st, input logic sp, input int ev,
                                input int er, input int ed);
        vec_t v;
        v.ld = ld; v.lt = lt; v.lu = lu; v.st = st; v.sp = sp;
        v.ev = ev; v.er = er; v.ed = ed;
        return v;
    endfunction

    initial begin
        // Expiry from 02 at PRESCALE=4, then start/stop ignored in EXPIRED.
        tbl[0]  = mk(1'b1, 4'd0, 4'd2, 1'b0, 1'b0, 2, 0, 0);
        tbl[1]  = mk(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 2, 1, 0);
        tbl[2]  = mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2, 1, 0);
        tbl[3]  = mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2, 1, 0);
        tbl[4]  = mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2, 1, 0);
        tbl[5]  = mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1, 1, 0);
        tbl[6]  = mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1, 1, 0);
        tbl[7]  = mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1, 1, 0);
        tbl[8]  = mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1, 1, 0);
        tbl[9]  = mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 0, 0, 1);
        tbl[10] = mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 0, 0, 0);
        tbl[11] = mk(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 0, 0, 0);
        tbl[12] = mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 0, 0, 0);

        clear = 1'b1; load = 1'b0; load_tens = 4'd0; load_units = 4'd0;
        start = 1'b0; stop = 1'b0;
        model_reset();
        #12;
        check("reset.tens", int'(t4), 9);
        check("reset.units", int'(u4), 9);
        check("reset.running", int'(r4), 0);
        check("reset.done", int'(d4), 0);
        check_models("reset");
        clear = 1'b0;

        // Start at 00 is ignored.
        step(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, "zero.load");
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, "zero.start");
        check("zero.running", int'(r4), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, "zero.hold");
            check("zero.done", int'(d4), 0);
        end

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].ld, tbl[i].lt, tbl[i].lu, tbl[i].st, tbl[i].sp,
                 $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.value", i), int'(t4) * 10 + int'(u4), tbl[i].ev);
            check($sformatf("tbl%0d.running", i), int'(r4), tbl[i].er);
            check($sformatf("tbl%0d.done", i), int'(d4), tbl[i].ed);
        end

        // Borrow across the digit boundary at PRESCALE=1.
        step(1'b1, 4'd2, 4'd0, 1'b0, 1'b0, "borrow.load");
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, "borrow.start");
        check("borrow.v20", int'(t1) * 10 + int'(u1), 20);
        check("borrow.run0", int'(r1), 1);
        idle(1, "borrow");
        check("borrow.v19", int'(t1) * 10 + int'(u1), 19);
        check("borrow.run1", int'(r1), 1);
        idle(1, "borrow");
        check("borrow.v18", int'(t1) * 10 + int'(u1), 18);
        check("borrow.run2", int'(r1), 1);

        // Pause and resume keeps the prescaler phase.
        step(1'b1, 4'd0, 4'd5, 1'b0, 1'b0, "pause.load");
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, "pause.start");
        idle(2, "pause.run");
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, "pause.stop");
        check("pause.running", int'(r4), 0);
        for (int i = 0; i < 10; i++) begin
            idle(1, "pause.hold");
            check("pause.held", int'(t4) * 10 + int'(u4), 5);
        end
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, "pause.resume");
        check("pause.resume.running", int'(r4), 1);
        idle(1, "pause.after1");
        check("pause.after1", int'(t4) * 10 + int'(u4), 5);
        idle(1, "pause.after2");
        check("pause.after2", int'(t4) * 10 + int'(u4), 4);

        // Clamping, then a load landing on a tick wins over the decrement.
        step(1'b1, 4'hF, 4'hC, 1'b0, 1'b0, "clamp.load");
        check("clamp.value", int'(t4) * 10 + int'(u4), 99);
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, "prio.start");
        idle(3, "prio.run");
        step(1'b1, 4'd3, 4'd3, 1'b0, 1'b0, "prio.load");
        check("prio.value", int'(t4) * 10 + int'(u4), 33);
        check("prio.running", int'(r4), 0);
        idle(2, "prio.idle");
        check("prio.idle.value", int'(t4) * 10 + int'(u4), 33);

        // Simultaneous stop and start in RUN pauses.
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, "both.start");
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1, "both.cmd");
        check("both.running", int'(r4), 0);

        // Clear mid-RUN returns to reset values without a clock edge.
        step(1'b1, 4'd5, 4'd0, 1'b0, 1'b0, "clr.load");
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, "clr.start");
        idle(2, "clr.run");
        async_clear("clr");

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic       ld, st, sp;
            logic [3:0] lt, lu;
            ld = ($urandom % 14) == 0;
            lt = (($urandom % 2) == 0) ? 4'($urandom % 2) : 4'($urandom % 16);
            lu = 4'($urandom % 16);
            st = ($urandom % 4) == 0;
            sp = ($urandom % 12) == 0;
            step(ld, lt, lu, st, sp, $sformatf("rnd%0d", i));
            if (($urandom % 150) == 0) async_clear($sformatf("rndclr%0d", i));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
